// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl -- hazard / stall / flush controller for a short in-order pipeline
// (IF/D -> EXM -> WB) with a synchronous instruction BRAM and slow memory
// accesses that complete on an acknowledge.
//
// Optional feature macro: PIPE_CTRL_PERF_EN
//   When defined, two free-running 32-bit performance counters are added
//   (stall_cycles, flush_cycles). When undefined they do not exist at all.
//
// Ports:
//   clk            in   1   sole clock, rising edge
//   rst_n          in   1   asynchronous active-low reset
//   exm_valid      in   1   EXM stage holds a real instruction
//   exm_rs1/rs2    in   5   EXM source register indices
//   exm_mem_req    in   1   EXM instruction needs a slow (acked) access
//   mem_ack        in   1   slow access completes this cycle
//   exm_redirect   in   1   EXM branch taken / jump
//   wb_valid       in   1   WB stage holds a real instruction
//   wb_RegWen      in   1   WB instruction writes the register file
//   wb_rd          in   5   WB destination register
//   if_stall       out  1   hold PC and IF/D register
//   exm_stall      out  1   hold the EXM instruction
//   fd_flush       out  1   replace IF/D instruction with a NOP
//   exm_wb_bubble  out  1   load a NOP into EXM/WB
//   fwd_a/fwd_b    out  1   EXM operand A/B takes the WB writeback value
//   mem_timeout    out  1   sticky: a slow access was abandoned
//   state          out  2   FSM state (debug)
//   stall_cycles   out  32  (PIPE_CTRL_PERF_EN) cycles with if_stall=1
//   flush_cycles   out  32  (PIPE_CTRL_PERF_EN) cycles with fd_flush=1
// ---------------------------------------------------------------------------
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exm_valid,
  input  logic [4:0]  exm_rs1,
  input  logic [4:0]  exm_rs2,
  input  logic        exm_mem_req,
  input  logic        mem_ack,
  input  logic        exm_redirect,
  input  logic        wb_valid,
  input  logic        wb_RegWen,
  input  logic [4:0]  wb_rd,
  output logic        if_stall,
  output logic        exm_stall,
  output logic        fd_flush,
  output logic        exm_wb_bubble,
  output logic        fwd_a,
  output logic        fwd_b,
  output logic        mem_timeout,
  output logic [1:0]  state
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_cycles
`endif
);

  localparam logic [1:0] RUN      = 2'b00;
  localparam logic [1:0] MEM_WAIT = 2'b01;
  localparam logic [1:0] REDIRECT = 2'b10;

  localparam logic [7:0] WAIT_LIMIT = 8'd255;

  logic [1:0] r_state;
  logic [7:0] r_waitCount;
  logic       r_memTimeout;

  logic [1:0] w_nextState;
  logic       w_stall;
  logic       w_flush;
  logic       w_timeoutHit;

  // Next-state and raw stall/flush decode. A memory request wins over a
  // simultaneous redirect; the redirect is then taken on the ack cycle, and
  // that ack cycle already flushes IF/D so two slots are flushed as in the
  // plain RUN redirect path. Hitting the wait limit abandons the access.
  always_comb begin
    w_nextState  = RUN;
    w_stall      = 1'b0;
    w_flush      = 1'b0;
    w_timeoutHit = 1'b0;
    case (r_state)
      RUN: begin
        if (exm_valid && exm_mem_req && !mem_ack) begin
          w_stall     = 1'b1;
          w_nextState = MEM_WAIT;
        end else if (exm_valid && exm_redirect) begin
          w_flush     = 1'b1;
          w_nextState = REDIRECT;
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          if (exm_redirect) begin
            w_flush     = 1'b1;
            w_nextState = REDIRECT;
          end
        end else if (r_waitCount == WAIT_LIMIT) begin
          w_timeoutHit = 1'b1;
        end else begin
          w_stall     = 1'b1;
          w_nextState = MEM_WAIT;
        end
      end
      REDIRECT: begin
        // EXM holds a flushed NOP here, so any redirect request is ignored.
        w_flush = 1'b1;
      end
      default: begin
        w_nextState = RUN;
      end
    endcase
  end

  // Control outputs are forced low while reset is asserted so they drop
  // immediately, without waiting for the state register to be clocked.
  assign if_stall      = rst_n & w_stall;
  assign exm_stall     = rst_n & w_stall;
  assign exm_wb_bubble = rst_n & w_stall;
  assign fd_flush      = rst_n & w_flush;

  // Forwarding from WB into EXM; register x0 is never forwarded.
  assign fwd_a = wb_valid & wb_RegWen & (wb_rd != 5'd0) & (wb_rd == exm_rs1);
  assign fwd_b = wb_valid & wb_RegWen & (wb_rd != 5'd0) & (wb_rd == exm_rs2);

  assign mem_timeout = r_memTimeout;
  assign state       = r_state;

  // State register, wait counter and sticky timeout flag. The counter only
  // advances on stalled MEM_WAIT cycles and sits at zero everywhere else,
  // which makes it zero on every entry into MEM_WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RUN;
      r_waitCount  <= 8'd0;
      r_memTimeout <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if ((r_state == MEM_WAIT) && w_stall) begin
        r_waitCount <= r_waitCount + 8'd1;
      end else begin
        r_waitCount <= 8'd0;
      end
      if (w_timeoutHit) begin
        r_memTimeout <= 1'b1;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stallCycles;
  logic [31:0] r_flushCycles;

  // Performance counters; they wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stallCycles <= 32'd0;
      r_flushCycles <= 32'd0;
    end else begin
      if (if_stall) begin
        r_stallCycles <= r_stallCycles + 32'd1;
      end
      if (fd_flush) begin
        r_flushCycles <= r_flushCycles + 32'd1;
      end
    end
  end

  assign stall_cycles = r_stallCycles;
  assign flush_cycles = r_flushCycles;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl -- self-checking bench for pipe_ctrl. Directed scenarios plus
// a randomized run checked against a cycle-level behavioural model of the
// pipeline controller (tracks "waiting on memory", "flush still owed" and
// elapsed wait cycles). Build with +define+PIPE_CTRL_PERF_EN to also check
// the performance counters.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       exm_valid, exm_mem_req, mem_ack, exm_redirect;
  logic       wb_valid, wb_RegWen;
  logic [4:0] exm_rs1, exm_rs2, wb_rd;
  logic       if_stall, exm_stall, fd_flush, exm_wb_bubble;
  logic       fwd_a, fwd_b, mem_timeout;
  logic [1:0] state;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles, flush_cycles;
`endif

  int testCount = 0;
  int failCount = 0;

  // Behavioural model state
  bit mWaiting;
  bit mFlushOwed;
  int mWaitCycles;
  bit mTimeout;
  int mStallTotal;
  int mFlushTotal;

  pipe_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .exm_valid(exm_valid), .exm_rs1(exm_rs1), .exm_rs2(exm_rs2),
    .exm_mem_req(exm_mem_req), .mem_ack(mem_ack), .exm_redirect(exm_redirect),
    .wb_valid(wb_valid), .wb_RegWen(wb_RegWen), .wb_rd(wb_rd),
    .if_stall(if_stall), .exm_stall(exm_stall), .fd_flush(fd_flush),
    .exm_wb_bubble(exm_wb_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_timeout(mem_timeout), .state(state)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
`endif
  );

  // 10 time-unit clock
  always #5 clk = ~clk;

  // Expected combinational outputs of the model for the current inputs.
  task automatic modelOutputs(output bit eStall, output bit eFlush,
                              output bit eFwdA, output bit eFwdB,
                              output logic [1:0] eState);
    eStall = 0;
    eFlush = 0;
    if (mFlushOwed) begin
      eFlush = 1;
    end else if (mWaiting) begin
      if (mem_ack) eFlush = exm_redirect;
      else eStall = (mWaitCycles < 255);
    end else begin
      if (exm_valid && exm_mem_req && !mem_ack) eStall = 1;
      else eFlush = exm_valid && exm_redirect;
    end
    eFwdA = wb_valid && wb_RegWen && wb_rd != 0 && wb_rd == exm_rs1;
    eFwdB = wb_valid && wb_RegWen && wb_rd != 0 && wb_rd == exm_rs2;
    eState = mFlushOwed ? 2'd2 : (mWaiting ? 2'd1 : 2'd0);
  endtask

  // Advance the model on each rising edge using the inputs the DUT sees.
  always @(posedge clk) begin
    bit s, f, a, b;
    logic [1:0] st;
    if (rst_n) begin
      modelOutputs(s, f, a, b, st);
      if (s) mStallTotal++;
      if (f) mFlushTotal++;
      if (mFlushOwed) begin
        mFlushOwed = 0;
      end else if (mWaiting) begin
        if (mem_ack) begin
          mWaiting = 0;
          mFlushOwed = exm_redirect;
        end else if (mWaitCycles >= 255) begin
          mWaiting = 0;
          mTimeout = 1;
        end else begin
          mWaitCycles++;
        end
      end else if (exm_valid && exm_mem_req && !mem_ack) begin
        mWaiting = 1;
        mWaitCycles = 0;
      end else if (exm_valid && exm_redirect) begin
        mFlushOwed = 1;
      end
    end
  end

  task automatic modelReset;
    mWaiting = 0; mFlushOwed = 0; mWaitCycles = 0; mTimeout = 0;
    mStallTotal = 0; mFlushTotal = 0;
  endtask

  task automatic applyStimulus(input bit v, input bit req, input bit ack,
                               input bit redir);
    exm_valid = v; exm_mem_req = req; mem_ack = ack; exm_redirect = redir;
  endtask

  task automatic driveIdle;
    applyStimulus(0, 0, 0, 0);
    wb_valid = 0; wb_RegWen = 0; wb_rd = 0; exm_rs1 = 0; exm_rs2 = 0;
  endtask

  task automatic doReset;
    @(negedge clk);
    rst_n = 0;
    driveIdle();
    modelReset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset;
    doReset();
    #1;
    testCount++;
    if ({state, if_stall, exm_stall, fd_flush, exm_wb_bubble, mem_timeout} !== 7'b0) begin
      failCount++;
      $display("[TB] FAIL reset_state: got state=%0d stall=%0b%0b%0b flush=%0b timeout=%0b, expected all 0",
               state, if_stall, exm_stall, exm_wb_bubble, fd_flush, mem_timeout);
    end
  endtask

  task automatic test_mem_wait;
    logic [1:0] expState [6] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
    int stallSeen = 0;
    int badState = 0;
    int badGroup = 0;
    doReset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      applyStimulus(1, c < 4, c == 3, 0);
      #1;
      if (if_stall) stallSeen++;
      if (state !== expState[c]) badState++;
      if (exm_stall !== if_stall || exm_wb_bubble !== if_stall) badGroup++;
    end
    testCount++;
    if (stallSeen != 3) begin
      failCount++;
      $display("[TB] FAIL mem_wait_stall_len: got %0d cycles, expected 3", stallSeen);
    end
    testCount++;
    if (badState != 0) begin
      failCount++;
      $display("[TB] FAIL mem_wait_states: %0d wrong state samples, expected 0", badState);
    end
    testCount++;
    if (badGroup != 0) begin
      failCount++;
      $display("[TB] FAIL mem_wait_stall_group: %0d inconsistent cycles, expected 0", badGroup);
    end
`ifdef PIPE_CTRL_PERF_EN
    testCount++;
    if (stall_cycles !== 32'd3) begin
      failCount++;
      $display("[TB] FAIL perf_stall_cycles: got %0d, expected 3", stall_cycles);
    end
`endif
  endtask

  task automatic test_redirect;
    logic [1:0] expState [4] = '{2'd0, 2'd2, 2'd0, 2'd0};
    int flushSeen = 0;
    int badState = 0;
    doReset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      applyStimulus(1, 0, 0, c == 0);
      #1;
      if (fd_flush) flushSeen++;
      if (state !== expState[c]) badState++;
    end
    testCount++;
    if (flushSeen != 2 || badState != 0) begin
      failCount++;
      $display("[TB] FAIL redirect_flush: got %0d flush cycles, %0d bad states; expected 2, 0",
               flushSeen, badState);
    end
`ifdef PIPE_CTRL_PERF_EN
    testCount++;
    if (flush_cycles !== 32'd2) begin
      failCount++;
      $display("[TB] FAIL perf_flush_cycles: got %0d, expected 2", flush_cycles);
    end
`endif
    // Redirect held through the REDIRECT cycle must not start a second flush
    flushSeen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      applyStimulus(1, 0, 0, c < 2);
      #1;
      if (fd_flush) flushSeen++;
    end
    testCount++;
    if (flushSeen != 2) begin
      failCount++;
      $display("[TB] FAIL redirect_ignored: got %0d flush cycles, expected 2", flushSeen);
    end
  endtask

  task automatic test_mem_redirect;
    logic [1:0] expState [5] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd0};
    bit expStall [5] = '{1, 1, 0, 0, 0};
    int bad = 0;
    doReset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      applyStimulus(c < 3, c < 3, c == 2, c < 3);
      #1;
      if (state !== expState[c] || if_stall !== expStall[c]) bad++;
    end
    testCount++;
    if (bad != 0) begin
      failCount++;
      $display("[TB] FAIL mem_then_redirect: %0d bad cycles, expected 0", bad);
    end
  endtask

  task automatic test_forwarding;
    @(negedge clk);
    wb_valid = 1; wb_RegWen = 1; wb_rd = 5; exm_rs1 = 5; exm_rs2 = 0;
    #1;
    testCount++;
    if (fwd_a !== 1'b1 || fwd_b !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL fwd_match: got a=%0b b=%0b, expected a=1 b=0", fwd_a, fwd_b);
    end
    wb_rd = 0; exm_rs1 = 0;
    #1;
    testCount++;
    if (fwd_a !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL fwd_x0: got a=%0b, expected 0", fwd_a);
    end
    wb_rd = 7; exm_rs1 = 3; exm_rs2 = 7; wb_RegWen = 0;
    #1;
    testCount++;
    if (fwd_b !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL fwd_no_wen: got b=%0b, expected 0", fwd_b);
    end
    driveIdle();
  endtask

  task automatic test_timeout;
    int waitCycles = 0;
    bit lastStall = 1;
    bit earlyRelease = 0;
    doReset();
    @(negedge clk);
    applyStimulus(1, 1, 0, 0);
    #1;
    while (1) begin
      @(negedge clk);
      #1;
      if (state !== 2'd1 || waitCycles > 300) break;
      lastStall = if_stall;
      if (waitCycles < 255 && !if_stall) earlyRelease = 1;
      waitCycles++;
    end
    testCount++;
    if (waitCycles != 256 || lastStall !== 1'b0 || earlyRelease) begin
      failCount++;
      $display("[TB] FAIL timeout_wait: got %0d wait cycles lastStall=%0b early=%0b, expected 256 0 0",
               waitCycles, lastStall, earlyRelease);
    end
    testCount++;
    if (mem_timeout !== 1'b1 || state !== 2'd0) begin
      failCount++;
      $display("[TB] FAIL timeout_flag: got timeout=%0b state=%0d, expected 1 0", mem_timeout, state);
    end
`ifdef PIPE_CTRL_PERF_EN
    testCount++;
    if (stall_cycles !== 32'd256) begin
      failCount++;
      $display("[TB] FAIL perf_timeout_stalls: got %0d, expected 256", stall_cycles);
    end
`endif
    applyStimulus(0, 0, 0, 0);
    for (int c = 0; c < 3; c++) @(negedge clk);
    #1;
    testCount++;
    if (mem_timeout !== 1'b1 || if_stall !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL timeout_sticky: got timeout=%0b stall=%0b, expected 1 0", mem_timeout, if_stall);
    end
  endtask

  task automatic test_async_reset;
    doReset();
    @(negedge clk);
    applyStimulus(1, 1, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 0;
    modelReset();
    #1;
    testCount++;
    if (state !== 2'd0 || if_stall !== 1'b0 || exm_stall !== 1'b0 || exm_wb_bubble !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL async_reset: got state=%0d stall=%0b%0b%0b, expected 0 000",
               state, if_stall, exm_stall, exm_wb_bubble);
    end
    @(negedge clk);
    applyStimulus(0, 0, 0, 0);
    rst_n = 1;
    #1;
    testCount++;
    if (state !== 2'd0 || if_stall !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL async_reset_release: got state=%0d stall=%0b, expected 0 0", state, if_stall);
    end
  endtask

  task automatic test_random;
    bit eStall, eFlush, eFwdA, eFwdB;
    logic [1:0] eState;
    int badCycles = 0;
    doReset();
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      applyStimulus($urandom_range(3) != 0, $urandom_range(3) == 0,
                    $urandom_range(1) == 1, $urandom_range(3) == 0);
      wb_valid = $urandom_range(3) != 0;
      wb_RegWen = $urandom_range(3) != 0;
      wb_rd = 5'($urandom_range(3));
      exm_rs1 = 5'($urandom_range(3));
      exm_rs2 = 5'($urandom_range(3));
      #1;
      modelOutputs(eStall, eFlush, eFwdA, eFwdB, eState);
      if (if_stall !== eStall || exm_stall !== eStall || exm_wb_bubble !== eStall ||
          fd_flush !== eFlush || fwd_a !== eFwdA || fwd_b !== eFwdB ||
          state !== eState || mem_timeout !== mTimeout) begin
        badCycles++;
        if (badCycles <= 5)
          $display("[TB] FAIL random_cycle %0d: got stall=%0b flush=%0b fwd=%0b%0b state=%0d, expected %0b %0b %0b%0b %0d",
                   c, if_stall, fd_flush, fwd_a, fwd_b, state, eStall, eFlush, eFwdA, eFwdB, eState);
      end
    end
    testCount++;
    if (badCycles != 0) begin
      failCount++;
      $display("[TB] FAIL random_model: %0d mismatching cycles, expected 0", badCycles);
    end
`ifdef PIPE_CTRL_PERF_EN
    @(negedge clk);
    applyStimulus(0, 0, 0, 0);
    #1;
    testCount++;
    if (stall_cycles !== 32'(mStallTotal) || flush_cycles !== 32'(mFlushTotal)) begin
      failCount++;
      $display("[TB] FAIL random_perf: got %0d/%0d, expected %0d/%0d",
               stall_cycles, flush_cycles, mStallTotal, mFlushTotal);
    end
`endif
  endtask

  // Scenario sequence
  initial begin
    rst_n = 0;
    driveIdle();
    modelReset();
    test_reset();
    test_mem_wait();
    test_redirect();
    test_mem_redirect();
    test_forwarding();
    test_timeout();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
